// File: rtl/mbgd_apb_pkg.sv
// -----------------------------------------------------------------------------
// mbgd_apb_pkg
// Shared definitions for the MBGD APB arbiter slice.
//   apb_state_e      : arbiter FSM encoding (IDLE=00, SETUP=01, ACCESS=10, DONE=11)
//   *_DEFAULT        : default address/data widths and ACCESS timeout limit
// No ports (package).
// -----------------------------------------------------------------------------
package mbgd_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } apb_state_e;

  localparam int ADDR_W_DEFAULT  = 8;
  localparam int DATA_W_DEFAULT  = 8;
  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mbgd_rr_picker.sv
// -----------------------------------------------------------------------------
// mbgd_rr_picker
// Combinational round-robin picker. Searches the request vector starting at
// (last_owner_i + 1) mod N_REQ and wrapping, returning the first hit.
// Ports:
//   req_i        in  N_REQ  request vector
//   last_owner_i in  IDX_W  index of the most recently completed owner
//   grant_o      out N_REQ  one-hot grant (all zero when no request)
//   grant_idx_o  out IDX_W  index of the granted requester
//   valid_o      out 1      at least one request present
// -----------------------------------------------------------------------------
module mbgd_rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_owner_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             valid_o
);

  int               cand;
  logic [IDX_W-1:0] candIdx;

  // Walk offsets 1..N_REQ from the last owner; the last owner itself is the
  // final candidate, so a lone requester is never starved.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    cand        = 0;
    candIdx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand    = (int'(last_owner_i) + k) % N_REQ;
      candIdx = IDX_W'(cand);
      if (!valid_o && req_i[candIdx]) begin
        valid_o          = 1'b1;
        grant_o[candIdx] = 1'b1;
        grant_idx_o      = candIdx;
      end
    end
  end

endmodule

// File: rtl/mbgd_apb_arbiter.sv
// -----------------------------------------------------------------------------
// mbgd_apb_arbiter
// Shares one APB slave port among N_REQ requesters. Grants round-robin,
// latches the winner's command and runs a SETUP/ACCESS sequence with pready
// wait states, then pulses done[owner] for one cycle with the read data.
// Optional feature: define MBGD_APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT cycles without pready (done pulses with err=1, rdata=0).
// Ports:
//   apb_pclk, reset          clock, asynchronous active-high reset
//   req/req_write            per-requester request (held until done) / direction
//   req_addr/req_wdata       packed per-requester address / write data
//   done, rdata, err         one-hot completion pulse, read data, timeout flag
//   busy, owner, state       status: busy in SETUP..DONE, current/last owner, FSM
//   apb_*                    APB master interface toward the MBGD slave
// -----------------------------------------------------------------------------
module mbgd_apb_arbiter
  import mbgd_apb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      apb_pclk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic [1:0]                state,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [ADDR_W-1:0]         apb_paddress,
  output logic [DATA_W-1:0]         apb_pwdata,
  input  logic [DATA_W-1:0]         apb_prdata,
  input  logic                      apb_pready
);

  localparam int OWN_W = $clog2(N_REQ);

  apb_state_e         state_q;
  logic [OWN_W-1:0]   owner_q;
  logic [OWN_W-1:0]   lastOwner_q;
  logic               psel_q;
  logic               penable_q;
  logic               pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [N_REQ-1:0]   done_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               busy_q;

  logic [N_REQ-1:0]   grant;
  logic [OWN_W-1:0]   grantIdx;
  logic               grantValid;

  logic               cmdWrite_d;
  logic [ADDR_W-1:0]  cmdAddr_d;
  logic [DATA_W-1:0]  cmdWdata_d;

`ifdef MBGD_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   accessCnt_q;
  logic               err_q;
`endif

  mbgd_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (OWN_W)
  ) u_picker (
    .req_i        (req),
    .last_owner_i (lastOwner_q),
    .grant_o      (grant),
    .grant_idx_o  (grantIdx),
    .valid_o      (grantValid)
  );

  // One-hot AND-OR select of the winner's command fields.
  always_comb begin
    cmdWrite_d = 1'b0;
    cmdAddr_d  = '0;
    cmdWdata_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        cmdWrite_d = req_write[i];
        cmdAddr_d  = req_addr[i*ADDR_W +: ADDR_W];
        cmdWdata_d = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbiter FSM. Every output comes straight from a register; the command is
  // latched at the grant edge so requester changes afterwards are ignored.
  always_ff @(posedge apb_pclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      lastOwner_q <= OWN_W'(N_REQ - 1);
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
`ifdef MBGD_APB_TIMEOUT_EN
      accessCnt_q <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            pwrite_q  <= cmdWrite_d;
            paddr_q   <= cmdAddr_d;
            pwdata_q  <= cmdWdata_d;
            owner_q   <= grantIdx;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef MBGD_APB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
`ifdef MBGD_APB_TIMEOUT_EN
          accessCnt_q <= '0;
`endif
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb_pready) begin
            if (!pwrite_q) begin
              rdata_q <= apb_prdata;
            end
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            done_q[owner_q] <= 1'b1;
            state_q         <= DONE;
          end
`ifdef MBGD_APB_TIMEOUT_EN
          // pready on the limit cycle wins, handled by the branch above.
          else if (accessCnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q           <= 1'b1;
            rdata_q         <= '0;
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            done_q[owner_q] <= 1'b1;
            state_q         <= DONE;
          end else begin
            accessCnt_q <= accessCnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          lastOwner_q <= owner_q;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rdata        = rdata_q;
  assign apb_psel     = psel_q;
  assign apb_penable  = penable_q;
  assign apb_pwrite   = pwrite_q;
  assign apb_paddress = paddr_q;
  assign apb_pwdata   = pwdata_q;

`ifdef MBGD_APB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mbgd_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mbgd_apb_arbiter
// Directed self-checking bench for mbgd_apb_arbiter (N_REQ=2, 8-bit addr/data).
// Honours MBGD_APB_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_mbgd_apb_arbiter;

  logic        apb_pclk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic [0:0]  owner;
  logic [1:0]  state;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [7:0]  apb_paddress;
  logic [7:0]  apb_pwdata;
  logic [7:0]  apb_prdata;
  logic        apb_pready;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_SETUP  = 2'b01;
  localparam logic [1:0] S_ACCESS = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  always #5 apb_pclk = ~apb_pclk;

  mbgd_apb_arbiter #(
    .N_REQ   (2),
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .apb_pclk     (apb_pclk),
    .reset        (reset),
    .req          (req),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .done         (done),
    .rdata        (rdata),
    .err          (err),
    .busy         (busy),
    .owner        (owner),
    .state        (state),
    .apb_psel     (apb_psel),
    .apb_penable  (apb_penable),
    .apb_pwrite   (apb_pwrite),
    .apb_paddress (apb_paddress),
    .apb_pwdata   (apb_pwdata),
    .apb_prdata   (apb_prdata),
    .apb_pready   (apb_pready)
  );

  // Single comparison point: counts, asserts and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic [7:0] prd, input logic rdy);
    req        = r;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    apb_prdata = prd;
    apb_pready = rdy;
  endtask

  // Bounded wait on negedges for a given FSM state; expiry shows up as a
  // failed state comparison.
  task automatic waitState(input logic [1:0] s, input string tag);
    int n;
    n = 0;
    while (state !== s && n < 60) begin
      @(negedge apb_pclk);
      n++;
    end
    checkOutput(tag, {30'd0, state}, {30'd0, s});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic g;
    int   cnt;

    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 1'b1);
    @(negedge apb_pclk);

    // Reset state
    checkOutput("rst_state", {30'd0, state}, {30'd0, S_IDLE});
    checkOutput("rst_psel", {31'd0, apb_psel}, 32'd0);
    checkOutput("rst_done", {30'd0, done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_owner", {31'd0, owner}, 32'd0);
    checkOutput("rst_rdata", {24'd0, rdata}, 32'd0);

    // 1. Single write from requester 0, pready tied high
    reset = 1'b0;
    applyStimulus(2'b01, 2'b01, 16'h0000, 16'h00EE, 8'h00, 1'b1);
    @(negedge apb_pclk);
    checkOutput("w_setup_state", {30'd0, state}, {30'd0, S_SETUP});
    checkOutput("w_setup_sel", {30'd0, apb_psel, apb_penable}, 32'h2);
    checkOutput("w_setup_addr", {24'd0, apb_paddress}, 32'h00);
    checkOutput("w_setup_wdata", {24'd0, apb_pwdata}, 32'hEE);
    checkOutput("w_setup_write", {31'd0, apb_pwrite}, 32'd1);
    checkOutput("w_setup_owner", {31'd0, owner}, 32'd0);
    checkOutput("w_setup_busy", {31'd0, busy}, 32'd1);
    @(negedge apb_pclk);
    checkOutput("w_access_state", {30'd0, state}, {30'd0, S_ACCESS});
    checkOutput("w_access_sel", {30'd0, apb_psel, apb_penable}, 32'h3);
    @(negedge apb_pclk);
    checkOutput("w_done_state", {30'd0, state}, {30'd0, S_DONE});
    checkOutput("w_done_vec", {30'd0, done}, 32'h1);
    checkOutput("w_done_sel", {30'd0, apb_psel, apb_penable}, 32'h0);
    checkOutput("w_done_busy", {31'd0, busy}, 32'd1);
    req = 2'b00;
    @(negedge apb_pclk);
    checkOutput("w_idle_state", {30'd0, state}, {30'd0, S_IDLE});
    checkOutput("w_idle_done", {30'd0, done}, 32'h0);
    checkOutput("w_idle_busy", {31'd0, busy}, 32'd0);

    // 2. Read from requester 1 with two wait states
    applyStimulus(2'b10, 2'b00, 16'h0100, 16'h0000, 8'hCC, 1'b0);
    @(negedge apb_pclk);
    checkOutput("r_setup_state", {30'd0, state}, {30'd0, S_SETUP});
    checkOutput("r_setup_owner", {31'd0, owner}, 32'd1);
    checkOutput("r_setup_addr", {24'd0, apb_paddress}, 32'h01);
    checkOutput("r_setup_write", {31'd0, apb_pwrite}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge apb_pclk);
      checkOutput("r_access_state", {30'd0, state}, {30'd0, S_ACCESS});
      if (i == 2) apb_pready = 1'b1;
    end
    @(negedge apb_pclk);
    checkOutput("r_done_vec", {30'd0, done}, 32'h2);
    checkOutput("r_rdata", {24'd0, rdata}, 32'hCC);
    checkOutput("r_err", {31'd0, err}, 32'd0);
    req = 2'b00;
    @(negedge apb_pclk);

    // 3. Fairness: both requesting, expected grant order 0,1,0,1
    applyStimulus(2'b11, 2'b11, 16'h2010, 16'h2211, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      g = (i % 2) == 1;
      waitState(S_SETUP, "fair_setup");
      checkOutput("fair_owner", {31'd0, owner}, {31'd0, g});
      waitState(S_DONE, "fair_done_state");
      checkOutput("fair_done_vec", {30'd0, done}, g ? 32'h2 : 32'h1);
      if (i == 3) req = 2'b00;
      else        req[g] = 1'b0;
      @(negedge apb_pclk);
      if (i < 3) req[g] = 1'b1;
    end
    waitState(S_IDLE, "fair_idle");

    // 5. Latched command: address change during ACCESS has no effect
    applyStimulus(2'b01, 2'b01, 16'h0000, 16'h0077, 8'h00, 1'b0);
    waitState(S_ACCESS, "latch_access");
    req_addr  = 16'h0055;
    req_wdata = 16'h0099;
    @(negedge apb_pclk);
    checkOutput("latch_addr", {24'd0, apb_paddress}, 32'h00);
    checkOutput("latch_wdata", {24'd0, apb_pwdata}, 32'h77);
    @(negedge apb_pclk);
    checkOutput("latch_addr2", {24'd0, apb_paddress}, 32'h00);
    apb_pready = 1'b1;
    @(negedge apb_pclk);
    checkOutput("latch_done_state", {30'd0, state}, {30'd0, S_DONE});
    checkOutput("latch_done_addr", {24'd0, apb_paddress}, 32'h00);
    req = 2'b00;
    @(negedge apb_pclk);

    // 4. Reset during ACCESS, then requester 1 restarts with owner=1
    applyStimulus(2'b10, 2'b00, 16'h0300, 16'h0000, 8'h3C, 1'b0);
    waitState(S_ACCESS, "rst_mid_access");
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_sel", {30'd0, apb_psel, apb_penable}, 32'h0);
    checkOutput("rst_mid_done", {30'd0, done}, 32'h0);
    checkOutput("rst_mid_state", {30'd0, state}, {30'd0, S_IDLE});
    @(negedge apb_pclk);
    reset = 1'b0;
    @(negedge apb_pclk);
    checkOutput("rst_rel_state", {30'd0, state}, {30'd0, S_SETUP});
    checkOutput("rst_rel_owner", {31'd0, owner}, 32'd1);
    apb_pready = 1'b1;
    waitState(S_DONE, "rst_rel_done_state");
    checkOutput("rst_rel_rdata", {24'd0, rdata}, 32'h3C);
    checkOutput("rst_rel_done", {30'd0, done}, 32'h2);
    req = 2'b00;
    @(negedge apb_pclk);

    // 6. Timeout behaviour with pready held low
    applyStimulus(2'b01, 2'b00, 16'h0002, 16'h0000, 8'h5A, 1'b0);
    waitState(S_ACCESS, "to_access");
`ifdef MBGD_APB_TIMEOUT_EN
    cnt = 0;
    while (state === S_ACCESS && cnt < 100) begin
      cnt++;
      @(negedge apb_pclk);
    end
    checkOutput("to_cycles", cnt, 32'd16);
    checkOutput("to_state", {30'd0, state}, {30'd0, S_DONE});
    checkOutput("to_err", {31'd0, err}, 32'd1);
    checkOutput("to_rdata", {24'd0, rdata}, 32'h00);
    checkOutput("to_done", {30'd0, done}, 32'h1);
`else
    cnt = 0;
    repeat (100) begin
      @(negedge apb_pclk);
      cnt++;
    end
    checkOutput("nto_state", {30'd0, state}, {30'd0, S_ACCESS});
    checkOutput("nto_err", {31'd0, err}, 32'd0);
    checkOutput("nto_sel", {30'd0, apb_psel, apb_penable}, 32'h3);
    apb_pready = 1'b1;
    @(negedge apb_pclk);
    checkOutput("nto_done", {30'd0, done}, 32'h1);
    checkOutput("nto_rdata", {24'd0, rdata}, 32'h5A);
`endif
    req = 2'b00;
    @(negedge apb_pclk);
    checkOutput("end_idle", {30'd0, state}, {30'd0, S_IDLE});

    $display("[TB] directed sequence complete after %0d timeout-phase cycles", cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mbgd_apb_arbiter.md
Name: mbgd_apb_arbiter

Overview:
- APB master-side arbiter and sequencer that shares the single MBGD APB slave port among N_REQ requesters, e.g. CPU config path and an autonomous parameter loader.
- Grants round-robin, latches the winner's command, and drives a fully compliant SETUP/ACCESS sequence with pready wait states.
- Returns read data and a one-cycle done pulse to the owner.
- Sits between the requesters and MBGD_top's apb_* port.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 8, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, max ACCESS cycles before abort (used only with the optional feature)

Ports:
apb_pclk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester transfer request, held until done
req_write  in  N_REQ  per-requester direction, 1 = write
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data, same packing
done  out  N_REQ  one-hot, one-cycle completion pulse to owner
rdata  out  DATA_W  read data, valid while done is high
err  out  1  timeout abort flag, valid while done is high
busy  out  1  high in SETUP, ACCESS and DONE
owner  out  $clog2(N_REQ)  index of current or last grant
state  out  2  FSM state
apb_psel  out  1  APB select
apb_penable  out  1  APB enable
apb_pwrite  out  1  APB direction
apb_paddress  out  ADDR_W  APB address
apb_pwdata  out  DATA_W  APB write data
apb_prdata  in  DATA_W  APB read data
apb_pready  in  1  APB ready

Behaviour:
- Reset values (asynchronous, immediate on reset high):
  - state=IDLE; all outputs 0; last_owner=N_REQ-1, so requester 0 has first priority.
- FSM encodings: IDLE=00, SETUP=01, ACCESS=10, DONE=11. All outputs are registered.
- IDLE:
  - If any req bit is high, pick the first requester at or after (last_owner+1) mod N_REQ, wrapping.
  - At the clock edge, latch that requester's write/addr/wdata into the command registers, set owner, go to SETUP.
  - With no req, stay in IDLE.
- SETUP (exactly 1 cycle): psel=1, penable=0, pwrite/paddress/pwdata driven from the latched command. Next state is ACCESS.
- ACCESS: psel=1, penable=1, address/data held stable.
  - pready=0: stay in ACCESS.
  - pready=1: capture prdata into rdata (reads only; writes leave rdata unchanged), go to DONE.
- DONE (1 cycle): psel=0, penable=0, done[owner]=1, last_owner<=owner, next state IDLE.
  - The requester must deassert req at the edge where it samples done high.
  - Arbitration is not performed in DONE.
- Latency: grant edge to done = 3 cycles with zero wait states; each pready-low cycle adds 1. Minimum transfer period is 4 cycles.
- Latched command: req/req_addr/req_wdata changes after the grant edge do not affect the transfer in flight.
- Requester dropping req mid-transfer: the transfer completes anyway and done still pulses.
- Reset mid-transfer: psel/penable/done drop immediately, and the partially performed access is not retried.
- pwdata is held from SETUP onward for writes. On reads it carries the last latched value, and the slave ignores it.
- owner width is 1 when N_REQ=2.

Optional Feature:
- Macro: MBGD_APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT with pready still low, the FSM goes to DONE with err=1 and rdata=0. done pulses normally.
  - pready=1 on the same cycle as the limit takes precedence: normal completion, err=0.
- Undefined: ACCESS waits indefinitely, err is tied to 0, and no counter logic is built.

Decomposition:
- Package mbgd_apb_pkg:
  - FSM state encodings: IDLE, SETUP, ACCESS, DONE.
  - Default ADDR_W/DATA_W constants.
  - TIMEOUT default.
- Sub-module mbgd_rr_picker: combinational, takes req and last_owner, returns a one-hot grant and its index. Parameterized by N_REQ.

Test Plan:
1. Single write: req[0]=1, write, addr 0x00, wdata 0xEE, pready tied 1 -> exactly 1 SETUP cycle (psel=1, penable=0, paddress=0x00, pwdata=0xEE), then 1 ACCESS cycle, then done[0] for 1 cycle. 3 cycles grant-to-done.
2. Read with wait states: req[1]=1, read, addr 0x01, prdata=0xCC, pready low for 2 ACCESS cycles -> ACCESS lasts 3 cycles, rdata=0xCC while done[1]=1, err=0.
3. Fairness: req[0] and req[1] held continuously after reset, each dropped on its done and reasserted 1 cycle later -> grant order 0,1,0,1. No requester is granted twice in a row while the other waits.
4. Reset during ACCESS: reset asserted -> psel, penable and done are 0 without waiting for a clock edge, state=00. After release with req[1] pending -> SETUP with owner=1 (priority restarted from 0, and 0 is idle).
5. Latched command: change req_addr[0] from 0x00 to 0x55 during ACCESS with pready held low -> paddress stays 0x00 until DONE.
6. Timeout, macro defined, TIMEOUT=16, pready held 0 -> done + err=1, rdata=0x00 after 16 ACCESS cycles. Macro undefined -> still in ACCESS after 100 cycles, err=0.
